// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned N_DEF = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for the serial adder: START/operands in, status and result out.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         co;
  logic         ov;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co, ov
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co, ov
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell; the one combinational slice shared by every serial step.
module serial_add_ctrl_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: N steps through one full adder with a registered carry,
// then publishes sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    ra_q, ra_d;
  logic [N-1:0]    rb_q, rb_d;
  logic [N-1:0]    rs_q, rs_d;
  logic [N-1:0]    s_q, s_d;
  logic            c_q, c_d;
  logic            co_q, co_d;
  logic            ov_q, ov_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  serial_add_ctrl_fa u_fa (
    .a_i  (ra_q[0]),
    .b_i  (rb_q[0]),
    .ci_i (c_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    s_d     = s_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          c_d     = bus.ci;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        ra_d  = {1'b0, ra_q[N-1:1]};
        rb_d  = {1'b0, rb_q[N-1:1]};
        rs_d  = {fa_s, rs_q[N-1:1]};
        c_d   = fa_co;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // On the last step c_q is the carry into the MSB.
          s_d     = rs_d;
          co_d    = fa_co;
          ov_d    = c_q ^ fa_co;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      s_q     <= s_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (N=8): directed adds, ignored START, abort, back-to-back.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t sb_q[$];

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        chk("sum", 32'(bus.s), 32'(e.s));
        chk("co", 32'(bus.co), 32'(e.co));
        chk("ov", 32'(bus.ov), 32'(e.ov));
      end
    end
  end

  task automatic push(input logic [N-1:0] s, input logic co, input logic ov);
    res_t r;
    r.s  = s;
    r.co = co;
    r.ov = ov;
    sb_q.push_back(r);
  endtask

  // Present operands for one edge, then scramble them to prove they were captured.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.ci    = ~ci;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) nbusy++;
    end while (bus.done !== 1'b1 && lat < 20);
  endtask

  task automatic add(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic ci, input logic [N-1:0] s, input logic co, input logic ov);
    int lat, nbusy;
    push(s, co, ov);
    issue(a, b, ci);
    wait_done(lat, nbusy);
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
  endtask

  initial begin
    int ndone, first, second;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_co", 32'(bus.co), 32'd0);
    chk("rst_ov", 32'(bus.ov), 32'd0);

    add("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 32'd0);
    chk("hold_s", 32'(bus.s), 32'h10);
    add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    add("t2b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    add("t3", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    // Abort: reset four steps into a run, no result and no done afterwards.
    issue(8'h11, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_s", 32'(bus.s), 32'd0);
    chk("abort_co", 32'(bus.co), 32'd0);
    chk("abort_ov", 32'(bus.ov), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // START pulsed during RUN is ignored.
    push(8'h46, 1'b0, 1'b0);
    issue(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    first = 0;
    for (int i = 5; i <= 16; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        first = i;
      end
    end
    chk("ignored_done_count", 32'(ndone), 32'd1);
    chk("ignored_latency", 32'(first), 32'd9);

    // Back-to-back: START held through DONE re-enters RUN immediately.
    push(8'h0B, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    issue(8'h05, 8'h06, 1'b0);
    ndone  = 0;
    first  = 0;
    second = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (first == 0) first = i;
        else second = i;
      end
      if (i == 8) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.ci    = 1'b0;
      end
      if (i == 10) bus.start = 1'b0;
    end
    chk("b2b_done_count", 32'(ndone), 32'd2);
    chk("b2b_first", 32'(first), 32'd9);
    chk("b2b_spacing", 32'(second - first), 32'd9);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
